// File: rtl/shape_select_seq.sv
// ----------------------------------------------------------------------------
// shape_select_seq
// Registered, frame-synchronised shape-channel selector. One of NCH packed
// pixel channels drives out_data. A new selection is queued with sel_load and
// takes effect only at a frame_tick, so the picture never tears mid-frame.
// With auto_en set, the selector steps to the next channel every DWELL frames.
//
// Optional build macro: SHAPE_SEL_BLANK_EN. When defined, each frame_tick that
// changes sel_active blanks out_data (forces 0) for one frame.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   ch_data     NCH*W packed channels, channel k = ch_data[k*W +: W]
//   sel_req     requested channel index (>= NCH maps to channel 0)
//   sel_load    1-cycle strobe, queues sel_req as the pending request
//   auto_en     1 = rotate channels every DWELL frames
//   frame_tick  1-cycle frame-start strobe
//   out_data    registered pixel code of the active channel
//   sel_active  channel index currently driving out_data
//   pending     a queued request is waiting for the next frame_tick
// ----------------------------------------------------------------------------
module shape_select_seq #(
    parameter int NCH   = 4,
    parameter int W     = 2,
    parameter int SELW  = 2,
    parameter int DWELL = 60
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH*W-1:0]  ch_data,
    input  logic [SELW-1:0]   sel_req,
    input  logic              sel_load,
    input  logic              auto_en,
    input  logic              frame_tick,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   sel_active,
    output logic              pending
);

    localparam logic [SELW:0]   NCH_L      = (SELW+1)'(NCH);
    localparam logic [SELW-1:0] LAST_CH    = SELW'(NCH - 1);
    localparam logic [15:0]     DWELL_LAST = 16'(DWELL - 1);

    logic [W-1:0]    out_q,   out_d;
    logic [SELW-1:0] sel_q,   sel_d;
    logic [SELW-1:0] psel_q,  psel_d;
    logic            pend_q,  pend_d;
    logic [15:0]     dwell_q, dwell_d;
    logic [SELW-1:0] req_idx;
    logic [W-1:0]    ch_sel;

`ifdef SHAPE_SEL_BLANK_EN
    logic            blank_q, blank_d;
`endif

    // Out-of-range requests fall back to channel 0.
    assign req_idx = ({1'b0, sel_req} < NCH_L) ? sel_req : '0;

    // sel_q is always < NCH, so the slice stays inside ch_data.
    assign ch_sel = ch_data[int'(sel_q)*W +: W];

    always_comb begin
        sel_d   = sel_q;
        psel_d  = psel_q;
        pend_d  = pend_q;
        dwell_d = dwell_q;
        out_d   = ch_sel;

        if (frame_tick) begin
            // Manual request (same-cycle bypass first, then queued) beats auto.
            if (sel_load) begin
                sel_d   = req_idx;
                pend_d  = 1'b0;
                dwell_d = '0;
            end else if (pend_q) begin
                sel_d   = psel_q;
                pend_d  = 1'b0;
                dwell_d = '0;
            end else if (auto_en) begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    sel_d   = (sel_q == LAST_CH) ? '0 : sel_q + 1'b1;
                end else begin
                    dwell_d = dwell_q + 16'd1;
                end
            end
        end else if (sel_load) begin
            // Later loads in the same frame overwrite earlier ones.
            psel_d = req_idx;
            pend_d = 1'b1;
        end

`ifdef SHAPE_SEL_BLANK_EN
        // Blank state is re-decided at every tick; it lasts exactly one frame.
        blank_d = blank_q;
        if (frame_tick) blank_d = (sel_d != sel_q);
        if (blank_q) out_d = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= '0;
            sel_q   <= '0;
            psel_q  <= '0;
            pend_q  <= 1'b0;
            dwell_q <= '0;
        end else begin
            out_q   <= out_d;
            sel_q   <= sel_d;
            psel_q  <= psel_d;
            pend_q  <= pend_d;
            dwell_q <= dwell_d;
        end
    end

`ifdef SHAPE_SEL_BLANK_EN
    always_ff @(posedge clk) begin
        if (reset) blank_q <= 1'b0;
        else       blank_q <= blank_d;
    end
`endif

    assign out_data   = out_q;
    assign sel_active = sel_q;
    assign pending    = pend_q;

endmodule
